// File: rtl/interruptus_pkg.sv
// Shared definitions for the interruptus timer peripheral: port offsets,
// control bit positions and the control readback helper.
package interruptus_pkg;

  localparam int NUM_PORTS = 5;

  localparam logic [2:0] OFS_T0   = 3'd0;
  localparam logic [2:0] OFS_T1   = 3'd1;
  localparam logic [2:0] OFS_T2   = 3'd2;
  localparam logic [2:0] OFS_T3   = 3'd3;
  localparam logic [2:0] OFS_CTRL = 3'd4;

  localparam int RUN  = 0;
  localparam int CLR  = 1;
  localparam int LEDR = 2;
  localparam int LEDO = 3;
  localparam int LEDG = 4;

  // CLR is a strobe, so it never shows up when the register is read back.
  function automatic logic [7:0] ctrl_readback(input logic [7:0] ctrl);
    logic [7:0] value;
    value      = ctrl;
    value[CLR] = 1'b0;
    return value;
  endfunction

endpackage

// File: rtl/interruptus_timer.sv
// Free-running 32-bit cycle counter with synchronous clear and count enable.
module interruptus_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  output logic [31:0] count
);

  logic [31:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/interruptus.sv
// Z80-bus I/O peripheral: 32-bit cycle timer read bytewise through a coherent
// shadow register, plus a control register driving run/clear and three LEDs.
module interruptus
  import interruptus_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = 8'h18,
  parameter logic [7:0] CTRL_RESET = 8'h01
) (
  input  logic        gclk1,
  input  logic        resetn,
  input  logic [19:0] A,
  inout  wire  [7:0]  d,
  input  logic        iorqn,
  input  logic        m1n,
  input  logic        intan,
  input  logic        rdn,
  input  logic        wrn,
  output logic        led_r,
  output logic        led_o,
  output logic        led_g
);

  logic [NUM_PORTS-1:0] sel;
  logic [NUM_PORTS-1:0] rd_sel;
  logic [NUM_PORTS-1:0] wr_sel;

  logic [31:0] timer_count;
  logic        timer_clear;
  logic [23:0] shadow_reg;
  logic [7:0]  ctrl_reg;
  logic        rd0_reg;
  logic [7:0]  port_data [NUM_PORTS];
  logic [7:0]  rdata;
  logic        oe;

  // The strobes and upper address lines play no part in decode.
  logic unused_inputs;
  assign unused_inputs = ^{iorqn, m1n, A[19:8]};

  // Read has priority: a write only decodes while rdn is high.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_decode
    assign sel[gi]    = intan && (A[7:0] == BASE_ADDR + 8'(gi));
    assign rd_sel[gi] = sel[gi] && !rdn;
    assign wr_sel[gi] = sel[gi] && !wrn && rdn;
  end

  assign timer_clear = wr_sel[OFS_CTRL] && d[CLR];

  interruptus_timer u_timer (
    .clk    (gclk1),
    .rst_n  (resetn),
    .clear  (timer_clear),
    .enable (ctrl_reg[RUN]),
    .count  (timer_count)
  );

  // Upper bytes are frozen on the first clock of a byte-0 read so that the
  // following byte reads all come from the same timer sample.
  always_ff @(posedge gclk1 or negedge resetn) begin
    if (!resetn) begin
      ctrl_reg   <= CTRL_RESET;
      shadow_reg <= '0;
      rd0_reg    <= 1'b0;
    end else begin
      rd0_reg <= rd_sel[OFS_T0];
      if (rd_sel[OFS_T0] && !rd0_reg) begin
        shadow_reg <= timer_count[31:8];
      end
      if (wr_sel[OFS_CTRL]) begin
        ctrl_reg <= d;
      end
    end
  end

  assign port_data[OFS_T0]   = timer_count[7:0];
  assign port_data[OFS_T1]   = shadow_reg[7:0];
  assign port_data[OFS_T2]   = shadow_reg[15:8];
  assign port_data[OFS_T3]   = shadow_reg[23:16];
  assign port_data[OFS_CTRL] = ctrl_readback(ctrl_reg);

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rd_sel[i]) begin
        rdata = rdata | port_data[i];
      end
    end
  end

  assign oe = |rd_sel;
  assign d  = oe ? rdata : 8'hzz;

  assign led_r = ctrl_reg[LEDR];
  assign led_o = ctrl_reg[LEDO];
  assign led_g = ctrl_reg[LEDG];

endmodule

// File: tb/tb_interruptus.sv
// Self-checking bench for interruptus: reference model plus scoreboard,
// a constant vector table for decode/control, and timer coherence sequences.
module tb_interruptus;

  logic        gclk1 = 1'b0;
  logic        resetn;
  logic [19:0] a;
  wire  [7:0]  d;
  logic        iorqn;
  logic        m1n;
  logic        intan;
  logic        rdn;
  logic        wrn;
  logic        led_r;
  logic        led_o;
  logic        led_g;

  logic        tb_oe;
  logic [7:0]  tb_d;

  int tests_run    = 0;
  int tests_failed = 0;

  // Released bus floats high so an idle bus reads FF.
  assign d = tb_oe ? tb_d : 8'hzz;
  for (genvar gi = 0; gi < 8; gi++) begin : g_pull
    pullup (d[gi]);
  end

  interruptus dut (
    .gclk1  (gclk1),
    .resetn (resetn),
    .A      (a),
    .d      (d),
    .iorqn  (iorqn),
    .m1n    (m1n),
    .intan  (intan),
    .rdn    (rdn),
    .wrn    (wrn),
    .led_r  (led_r),
    .led_o  (led_o),
    .led_g  (led_g)
  );

  always #5 gclk1 = ~gclk1;

  // Reference model state
  logic [31:0] m_timer;
  logic [23:0] m_shadow;
  logic [7:0]  m_ctrl;
  logic        m_rd0;

  typedef struct {
    string      name;
    logic [7:0] d;
    logic [2:0] leds;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [19:0] a;
    logic        intan;
    logic        rdn;
    logic        wrn;
    logic [7:0]  wd;
    logic [7:0]  exp_d;
    logic [2:0]  exp_leds;
  } vec_t;
  vec_t vt[26];

  function automatic logic msel(input int n);
    logic [7:0] base;
    base = 8'h18;
    return intan && (a[7:0] == base + 8'(n));
  endfunction

  function automatic logic mrd(input int n);
    return msel(n) && !rdn;
  endfunction

  function automatic logic mwr(input int n);
    return msel(n) && !wrn && rdn;
  endfunction

  function automatic logic [7:0] model_bus();
    if (mrd(0)) return m_timer[7:0];
    if (mrd(1)) return m_shadow[7:0];
    if (mrd(2)) return m_shadow[15:8];
    if (mrd(3)) return m_shadow[23:16];
    if (mrd(4)) return m_ctrl & 8'hFD;
    if (tb_oe)  return tb_d;
    return 8'hFF;
  endfunction

  function automatic logic [2:0] model_leds();
    return {m_ctrl[4], m_ctrl[3], m_ctrl[2]};
  endfunction

  task automatic model_reset();
    m_timer  = '0;
    m_shadow = '0;
    m_ctrl   = 8'h01;
    m_rd0    = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] t;
    t = m_timer;
    if (!resetn) return;
    if (mwr(4) && tb_d[1]) m_timer = '0;
    else if (m_ctrl[0])    m_timer = m_timer + 32'd1;
    if (mrd(0) && !m_rd0) m_shadow = t[31:8];
    m_rd0 = mrd(0);
    if (mwr(4)) m_ctrl = {tb_d[7:2], 1'b0, tb_d[0]};
  endtask

  task automatic drive(input logic [19:0] addr, input logic ia, input logic r,
                       input logic w, input logic [7:0] wd);
    a     = addr;
    intan = ia;
    rdn   = r;
    wrn   = w;
    tb_d  = wd;
    tb_oe = !w && r;
  endtask

  task automatic idle();
    drive(20'h00000, 1'b1, 1'b1, 1'b1, 8'h00);
  endtask

  task automatic check_out();
    exp_t e;
    e = sbq.pop_front();
    tests_run++;
    if (d !== e.d) begin
      tests_failed++;
      $display("FAIL %s d: got %02h want %02h", e.name, d, e.d);
    end
    tests_run++;
    if ({led_g, led_o, led_r} !== e.leds) begin
      tests_failed++;
      $display("FAIL %s leds(g,o,r): got %03b want %03b", e.name,
               {led_g, led_o, led_r}, e.leds);
    end
    if (e.name != "spin")
      $display("[TB] %s A=%05h rdn=%0b wrn=%0b intan=%0b d=%02h leds=%03b",
               e.name, a, rdn, wrn, intan, d, {led_g, led_o, led_r});
  endtask

  // One bus clock: expectation queued at drive time, compared before the edge.
  task automatic run_step(input string name, input logic [7:0] ed, input logic [2:0] el);
    exp_t e;
    e.name = name;
    e.d    = ed;
    e.leds = el;
    sbq.push_back(e);
    #2;
    check_out();
    @(posedge gclk1);
    model_edge();
    @(negedge gclk1);
  endtask

  task automatic step(input string name);
    run_step(name, model_bus(), model_leds());
  endtask

  task automatic spin_to(input logic [31:0] target);
    idle();
    for (int i = 0; i < 2000 && m_timer != target; i++) step("spin");
    tests_run++;
    if (m_timer != target) begin
      tests_failed++;
      $display("FAIL spin_to: got %08h want %08h", m_timer, target);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{20'h0001C, 1'b1, 1'b1, 1'b0, 8'h02, 8'h02, 3'b000};
    vt[1]  = '{20'h00018, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 3'b000};
    vt[2]  = '{20'h00000, 1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 3'b000};
    vt[3]  = '{20'h0001C, 1'b1, 1'b1, 1'b0, 8'h1C, 8'h1C, 3'b000};
    vt[4]  = '{20'h00000, 1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 3'b111};
    vt[5]  = '{20'h0001C, 1'b1, 1'b0, 1'b1, 8'h00, 8'h1C, 3'b111};
    vt[6]  = '{20'h0001C, 1'b0, 1'b1, 1'b0, 8'hE4, 8'hE4, 3'b111};
    vt[7]  = '{20'h0001C, 1'b1, 1'b0, 1'b1, 8'h00, 8'h1C, 3'b111};
    vt[8]  = '{20'h2011C, 1'b1, 1'b1, 1'b0, 8'hA8, 8'hA8, 3'b111};
    vt[9]  = '{20'hFFF1C, 1'b1, 1'b0, 1'b1, 8'h00, 8'hA8, 3'b010};
    vt[10] = '{20'h0001C, 1'b1, 1'b0, 1'b0, 8'h37, 8'hA8, 3'b010};
    vt[11] = '{20'h0001C, 1'b1, 1'b0, 1'b1, 8'h00, 8'hA8, 3'b010};
    vt[12] = '{20'h0001D, 1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 3'b010};
    vt[13] = '{20'h00017, 1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 3'b010};
    vt[14] = '{20'h00019, 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 3'b010};
    vt[15] = '{20'h00018, 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 3'b010};
    vt[16] = '{20'h01000, 1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 3'b010};
    vt[17] = '{20'h01000, 1'b1, 1'b1, 1'b0, 8'h5C, 8'h5C, 3'b010};
    vt[18] = '{20'h0001C, 1'b1, 1'b0, 1'b1, 8'h00, 8'hA8, 3'b010};
    vt[19] = '{20'h0001A, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 3'b010};
    vt[20] = '{20'h0001C, 1'b1, 1'b1, 1'b0, 8'h5F, 8'h5F, 3'b010};
    vt[21] = '{20'h00018, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 3'b111};
    vt[22] = '{20'h00018, 1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 3'b111};
    vt[23] = '{20'h00018, 1'b1, 1'b0, 1'b1, 8'h00, 8'h02, 3'b111};
    vt[24] = '{20'h0001C, 1'b1, 1'b0, 1'b1, 8'h00, 8'h5D, 3'b111};
    vt[25] = '{20'h0001C, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 3'b111};

    iorqn  = 1'b1;
    m1n    = 1'b1;
    resetn = 1'b0;
    idle();
    model_reset();
    @(negedge gclk1);

    // Reset state
    step("rst_idle0");
    step("rst_idle1");
    drive(20'h00018, 1'b1, 1'b0, 1'b1, 8'h00);
    step("rst_read_t0");
    idle();
    resetn = 1'b1;

    // Idle count, then held byte-0 read and upper bytes
    for (int i = 0; i < 5; i++) step("idle_count");
    drive(20'h00018, 1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) step("held_t0");
    drive(20'h00019, 1'b1, 1'b0, 1'b1, 8'h00); step("rd_t1");
    drive(20'h0001A, 1'b1, 1'b0, 1'b1, 8'h00); step("rd_t2");
    drive(20'h0001B, 1'b1, 1'b0, 1'b1, 8'h00); step("rd_t3");

    // Held read across a carry must capture only once
    spin_to(32'h0000_01FD);
    drive(20'h00018, 1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) step("carry_held_t0");
    drive(20'h00019, 1'b1, 1'b0, 1'b1, 8'h00); step("carry_held_t1");
    drive(20'h0001A, 1'b1, 1'b0, 1'b1, 8'h00); step("carry_held_t2");

    // Single-clock byte-0 read at xxFF captures the pre-increment upper bytes
    spin_to(32'h0000_02FF);
    drive(20'h00018, 1'b1, 1'b0, 1'b1, 8'h00); step("carry_t0");
    idle(); step("carry_gap");
    drive(20'h00019, 1'b1, 1'b0, 1'b1, 8'h00); step("carry_t1");

    // Reset in the middle of a byte-1 read clears the shadow immediately
    resetn = 1'b0;
    model_reset();
    step("rst_midread");
    idle();
    step("rst_hold");
    resetn = 1'b1;

    // Decode and control register vectors
    for (int i = 0; i < 26; i++) begin
      drive(vt[i].a, vt[i].intan, vt[i].rdn, vt[i].wrn, vt[i].wd);
      run_step($sformatf("vec%0d", i), vt[i].exp_d, vt[i].exp_leds);
    end

    // Stopped timer holds its value
    drive(20'h00018, 1'b1, 1'b0, 1'b1, 8'h00);
    run_step("frozen_t0_a", 8'h05, 3'b000);
    idle();
    for (int i = 0; i < 10; i++) step("frozen_gap");
    drive(20'h00018, 1'b1, 1'b0, 1'b1, 8'h00);
    run_step("frozen_t0_b", 8'h05, 3'b000);
    idle();
    step("final_idle");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
